stream_mux_n: RTL and testbench

STREAM_MUX_N -- requirements
Module: stream_mux_n

---
 rtl/stream_mux_n.sv | 118 +++++++++++
 tb/tb_stream_mux_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_n.sv
// ============================================================================
// stream_mux_n : N-channel valid/ready stream multiplexer with registered output
//                (external select or round-robin arbitration)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module stream_mux_n #(
   parameter int MXwidth = 32,
   parameter int NCH     = 4,
   parameter int MODE    = 0,
   localparam int SW     = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH*MXwidth-1:0] s_data,
   input  logic [NCH-1:0]         s_valid,
   output logic [NCH-1:0]         s_ready,
   input  logic [SW-1:0]          sel,
   output logic [MXwidth-1:0]     m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [SW-1:0]          m_chan
);

   localparam logic [SW:0]   c_nch      = (SW+1)'(NCH);
   localparam logic [SW-1:0] c_last_ch  = SW'(NCH-1);

   logic [SW-1:0]      r_ptr;
   logic               w_load_en;
   logic               w_gvalid;
   logic [SW-1:0]      w_grant;
   logic [SW-1:0]      w_ptr_next;
   logic [MXwidth-1:0] w_gdata;

   assign w_load_en = !m_valid || m_ready;

   generate
      if (MODE == 1) begin : g_rr
         logic w_unused_sel;
         assign w_unused_sel = ^sel;

         // Reverse scan so the last hit is the first channel at or after r_ptr.
         always_comb begin
            logic [SW:0] idx;
            idx      = '0;
            w_gvalid = 1'b0;
            w_grant  = '0;
            for (int k = NCH-1; k >= 0; k--) begin
               idx = {1'b0, r_ptr} + (SW+1)'(k);
               if (idx >= c_nch) begin
                  idx = idx - c_nch;
               end
               if (s_valid[idx[SW-1:0]]) begin
                  w_gvalid = 1'b1;
                  w_grant  = idx[SW-1:0];
               end
            end
         end
      end else begin : g_sel
         logic w_unused_ptr;
         assign w_unused_ptr = ^r_ptr;

         // Out-of-range select values never match a channel, so they never grant.
         always_comb begin
            w_gvalid = 1'b0;
            w_grant  = '0;
            for (int i = 0; i < NCH; i++) begin
               if (sel == SW'(i) && s_valid[i]) begin
                  w_gvalid = 1'b1;
                  w_grant  = SW'(i);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      w_gdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant == SW'(i)) begin
            w_gdata = s_data[i*MXwidth +: MXwidth];
         end
      end
   end

   always_comb begin
      s_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         s_ready[i] = !rst && w_load_en && w_gvalid && (w_grant == SW'(i));
      end
   end

   assign w_ptr_next = (w_grant == c_last_ch) ? '0 : w_grant + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_chan  <= '0;
         r_ptr   <= '0;
      end else if (w_load_en) begin
         if (w_gvalid) begin
            m_valid <= 1'b1;
            m_data  <= w_gdata;
            m_chan  <= w_grant;
            if (MODE == 1) begin
               r_ptr <= w_ptr_next;
            end
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_n.sv
// ============================================================================
// tb_stream_mux_n : directed bench for stream_mux_n in select and round-robin modes
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // dut0: MODE=0, NCH=4, 32-bit
   logic [127:0] sd0;
   logic [3:0]   sv0, sr0;
   logic [1:0]   sel0, mc0;
   logic         mr0, mv0;
   logic [31:0]  md0;
   // dut1: MODE=1, NCH=4, 16-bit
   logic [63:0]  sd1;
   logic [3:0]   sv1, sr1;
   logic [1:0]   sel1, mc1;
   logic         mr1, mv1;
   logic [15:0]  md1;
   // dut2: MODE=1, NCH=3, 8-bit
   logic [23:0]  sd2;
   logic [2:0]   sv2, sr2;
   logic [1:0]   sel2, mc2;
   logic         mr2, mv2;
   logic [7:0]   md2;
   // dut3: MODE=0, NCH=3, 8-bit (select value 3 is out of range)
   logic [23:0]  sd3;
   logic [2:0]   sv3, sr3;
   logic [1:0]   sel3, mc3;
   logic         mr3, mv3;
   logic [7:0]   md3;

   stream_mux_n #(.MXwidth(32), .NCH(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .s_data(sd0), .s_valid(sv0), .s_ready(sr0), .sel(sel0),
      .m_data(md0), .m_valid(mv0), .m_ready(mr0), .m_chan(mc0));
   stream_mux_n #(.MXwidth(16), .NCH(4), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .s_data(sd1), .s_valid(sv1), .s_ready(sr1), .sel(sel1),
      .m_data(md1), .m_valid(mv1), .m_ready(mr1), .m_chan(mc1));
   stream_mux_n #(.MXwidth(8), .NCH(3), .MODE(1)) dut2 (
      .clk(clk), .rst(rst), .s_data(sd2), .s_valid(sv2), .s_ready(sr2), .sel(sel2),
      .m_data(md2), .m_valid(mv2), .m_ready(mr2), .m_chan(mc2));
   stream_mux_n #(.MXwidth(8), .NCH(3), .MODE(0)) dut3 (
      .clk(clk), .rst(rst), .s_data(sd3), .s_valid(sv3), .s_ready(sr3), .sel(sel3),
      .m_data(md3), .m_valid(mv3), .m_ready(mr3), .m_chan(mc3));

   typedef struct {
      logic [3:0]  sv;
      logic [1:0]  sel;
      logic        mr;
      logic [3:0]  exp_rdy;
      logic        exp_mv;
      logic [31:0] exp_data;
      logic [1:0]  exp_chan;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                sv       sel   mr    rdy      mv    data           chan
      vecs[0] = '{4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 32'hA5A5A5A5, 2'd2};
      vecs[1] = '{4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1, 32'hA5A5A5A5, 2'd2};
      vecs[2] = '{4'b1000, 2'd3, 1'b0, 4'b0000, 1'b1, 32'hA5A5A5A5, 2'd2};
      vecs[3] = '{4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3};
      vecs[4] = '{4'b1110, 2'd0, 1'b1, 4'b0000, 1'b0, 32'h44444444, 2'd3};
      vecs[5] = '{4'b1110, 2'd0, 1'b0, 4'b0000, 1'b0, 32'h44444444, 2'd3};
      vecs[6] = '{4'b1111, 2'd1, 1'b0, 4'b0010, 1'b1, 32'h22222222, 2'd1};
      vecs[7] = '{4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0};
      vecs[8] = '{4'b0000, 2'd2, 1'b1, 4'b0000, 1'b0, 32'h11111111, 2'd0};

      sd0 = {32'h44444444, 32'hA5A5A5A5, 32'h22222222, 32'h11111111};
      sd1 = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
      sd2 = {8'h0C, 8'h0B, 8'h0A};
      sd3 = {8'h3C, 8'h3B, 8'h3A};
      sv0 = 4'hF; sv1 = 4'hF; sv2 = 3'b111; sv3 = 3'b111;
      sel0 = 2'd2; sel1 = 2'd0; sel2 = 2'd0; sel3 = 2'd1;
      mr0 = 1'b1; mr1 = 1'b1; mr2 = 1'b1; mr3 = 1'b1;

      // Reset state with every channel requesting
      #12;
      chk("rst dut0 m_valid", mv0, 1'b0);
      chk("rst dut0 m_data", md0, 32'h0);
      chk("rst dut0 m_chan", mc0, 2'd0);
      chk("rst dut0 s_ready", sr0, 4'b0000);
      chk("rst dut1 m_valid", mv1, 1'b0);
      chk("rst dut1 s_ready", sr1, 4'b0000);
      chk("rst dut2 s_ready", sr2, 3'b000);
      chk("rst dut2 ptr", dut2.r_ptr, 2'd0);
      chk("rst dut3 s_ready", sr3, 3'b000);
      sv0 = '0; sv1 = '0; sv2 = '0; sv3 = '0;
      @(negedge clk);
      rst = 1'b0;

      // External-select table
      for (int i = 0; i < 9; i++) begin
         sv0 = vecs[i].sv; sel0 = vecs[i].sel; mr0 = vecs[i].mr;
         #1;
         chk($sformatf("v%0d s_ready", i), sr0, vecs[i].exp_rdy);
         tick();
         chk($sformatf("v%0d m_valid", i), mv0, vecs[i].exp_mv);
         chk($sformatf("v%0d m_data", i), md0, vecs[i].exp_data);
         chk($sformatf("v%0d m_chan", i), mc0, vecs[i].exp_chan);
      end
      sv0 = '0;

      // Out-of-range select drains the pending beat then idles
      sel3 = 2'd1; sv3 = 3'b111; mr3 = 1'b1;
      #1; chk("oor first s_ready", sr3, 3'b010);
      tick();
      chk("oor first m_valid", mv3, 1'b1);
      chk("oor first m_data", md3, 8'h3B);
      sel3 = 2'd3;
      #1; chk("oor sel3 s_ready", sr3, 3'b000);
      tick();
      chk("oor drained m_valid", mv3, 1'b0);
      chk("oor held m_data", md3, 8'h3B);
      chk("oor held m_chan", mc3, 2'd1);
      sv3 = '0;

      // Round-robin, all channels requesting
      for (int k = 0; k < 8; k++) begin
         sv1 = 4'hF; mr1 = 1'b1;
         #1; chk($sformatf("rr%0d s_ready", k), sr1, 4'b0001 << (k % 4));
         tick();
         chk($sformatf("rr%0d m_chan", k), mc1, k % 4);
         chk($sformatf("rr%0d m_data", k), md1, 16'h1000 * (k % 4 + 1));
         chk($sformatf("rr%0d m_valid", k), mv1, 1'b1);
      end

      // Downstream stall holds the beat
      mr1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1; chk($sformatf("stall%0d s_ready", k), sr1, 4'b0000);
         tick();
         chk($sformatf("stall%0d m_data", k), md1, 16'h4000);
         chk($sformatf("stall%0d m_chan", k), mc1, 2'd3);
         chk($sformatf("stall%0d m_valid", k), mv1, 1'b1);
      end
      mr1 = 1'b1;
      #1; chk("resume s_ready", sr1, 4'b0001);
      tick();
      chk("resume m_chan", mc1, 2'd0);
      chk("resume m_data", md1, 16'h1000);

      // Round-robin skipping idle channels
      sv1 = 4'b1010;
      #1; chk("skip1 s_ready", sr1, 4'b0010);
      tick(); chk("skip1 m_chan", mc1, 2'd1);
      sv1 = 4'b1001;
      #1; chk("skip2 s_ready", sr1, 4'b1000);
      tick(); chk("skip2 m_data", md1, 16'h4000);
      sv1 = 4'b0100;
      #1; chk("skip3 s_ready", sr1, 4'b0100);
      tick(); chk("skip3 m_chan", mc1, 2'd2);

      // Asynchronous reset between edges while a beat is held
      sv1 = 4'b1010; mr1 = 1'b0;
      #2; rst = 1'b1;
      #1;
      chk("arst m_valid", mv1, 1'b0);
      chk("arst m_data", md1, 16'h0);
      chk("arst m_chan", mc1, 2'd0);
      chk("arst s_ready", sr1, 4'b0000);
      chk("arst ptr", dut1.r_ptr, 2'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mr1 = 1'b1;
      #1; chk("post-rst s_ready", sr1, 4'b0010);
      tick();
      chk("post-rst m_chan", mc1, 2'd1);
      chk("post-rst m_data", md1, 16'h2000);
      sv1 = '0;

      // NCH=3 round-robin: only ch2 requesting, pointer wraps to 0
      for (int k = 0; k < 3; k++) begin
         sv2 = 3'b100; mr2 = 1'b1;
         #1; chk($sformatf("n3ch2_%0d s_ready", k), sr2, 3'b100);
         tick();
         chk($sformatf("n3ch2_%0d m_chan", k), mc2, 2'd2);
         chk($sformatf("n3ch2_%0d m_data", k), md2, 8'h0C);
         chk($sformatf("n3ch2_%0d ptr", k), dut2.r_ptr, 2'd0);
      end
      sv2 = 3'b011;
      #1; chk("n3a s_ready", sr2, 3'b001);
      tick(); chk("n3a m_chan", mc2, 2'd0); chk("n3a ptr", dut2.r_ptr, 2'd1);
      sv2 = 3'b111;
      #1; chk("n3b s_ready", sr2, 3'b010);
      tick(); chk("n3b m_chan", mc2, 2'd1); chk("n3b ptr", dut2.r_ptr, 2'd2);
      #1; chk("n3c s_ready", sr2, 3'b100);
      tick(); chk("n3c m_chan", mc2, 2'd2); chk("n3c ptr", dut2.r_ptr, 2'd0);
      sv2 = 3'b000;
      #1; chk("n3 idle s_ready", sr2, 3'b000);
      tick(); chk("n3 idle m_valid", mv2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
